// File: rtl/adc_fft_buf_reader_if.sv
// Sample stream from the buffer reader to the FFT input stage:
// a valid/ready beat carrying one sample plus an end-of-frame marker.
interface adc_fft_buf_reader_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic          last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/adc_fft_buf_reader.sv
// Read-side controller for the ADC->FFT sample buffer. It fetches one frame
// from RAM port B, hides the RAM read latency with a valid pipe, and feeds a
// small skid FIFO. Reads are issued only while the FIFO has room for every
// read already in flight, so the FIFO can never overflow.
module adc_fft_buf_reader #(
    parameter int AW         = 12,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW-1:0]        frame_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        ram_adb,
    output logic                 ram_ceb,
    output logic                 ram_oce,
    input  logic [DW-1:0]        ram_dout,
    adc_fft_buf_reader_if.master m
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   ONE_C    = (AW + 1)'(1);

    // FLUSH is the one-cycle gap between an abort and its done pulse.
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, FIN} state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       rd_addr_reg, rd_addr_next;
    logic [AW:0]         issue_cnt_reg, issue_cnt_next;
    logic [AW:0]         beat_cnt_reg, beat_cnt_next;
    logic [RD_LAT-1:0]   vld_pipe_reg, vld_pipe_next;
    logic [DW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]       count_reg;
    logic [CW:0]         inflight, outstanding;
    logic                issue, flush, fifo_wr, fifo_rd, handshake;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Read-valid pipe: stage 0 takes the read issued this cycle.
    assign vld_pipe_next[0] = issue;
    genvar gi;
    generate
        for (gi = 1; gi < RD_LAT; gi++) begin : g_pipe
            assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
        end
    endgenerate

    // Data leaves the RAM exactly when its valid leaves the pipe.
    assign fifo_wr   = vld_pipe_reg[RD_LAT-1];
    assign handshake = m.valid && m.ready;
    assign fifo_rd   = handshake;

    // Stream side is driven straight from the FIFO head; zero when empty.
    assign m.valid = (count_reg != '0);
    assign m.data  = m.valid ? fifo_mem[rd_ptr_reg] : '0;
    assign m.last  = m.valid && (beat_cnt_reg == ONE_C);

    assign ram_oce = 1'b1;
    assign ram_adb = rd_addr_reg;
    assign ram_ceb = issue;

    // Reads in flight = set bits of the valid pipe; credit uses in-flight + stored.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {{CW{1'b0}}, vld_pipe_reg[i]};
        end
        outstanding = inflight + {1'b0, count_reg};
    end

    // Next-state, issue decision and status outputs.
    always_comb begin
        state_next     = state_reg;
        rd_addr_next   = rd_addr_reg;
        issue_cnt_next = issue_cnt_reg;
        beat_cnt_next  = beat_cnt_reg;
        issue          = 1'b0;
        flush          = 1'b0;
        busy           = (state_reg == RUN) || (state_reg == DRAIN) || (state_reg == FLUSH);
        done           = (state_reg == FIN);
        case (state_reg)
            IDLE, FIN: begin
                if (start) begin
                    rd_addr_next   = base_addr;
                    // A zero length means a full buffer of 2^AW samples.
                    issue_cnt_next = (frame_len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, frame_len};
                    beat_cnt_next  = issue_cnt_next;
                    state_next     = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = FLUSH;
                end else begin
                    issue = (state_reg == RUN) && (issue_cnt_reg != '0) && (outstanding < DEPTH_C);
                    if (issue) begin
                        rd_addr_next   = rd_addr_reg + 1'b1;
                        issue_cnt_next = issue_cnt_reg - 1'b1;
                    end
                    if (handshake) begin
                        beat_cnt_next = beat_cnt_reg - 1'b1;
                    end
                    if (handshake && (beat_cnt_reg == ONE_C)) begin
                        state_next = FIN;
                    end else if ((state_reg == RUN) && (issue_cnt_next == '0)) begin
                        state_next = DRAIN;
                    end
                end
            end
            FLUSH:   state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    // Control registers, valid pipe and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_addr_reg   <= '0;
            issue_cnt_reg <= '0;
            beat_cnt_reg  <= '0;
            vld_pipe_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            issue_cnt_reg <= issue_cnt_next;
            beat_cnt_reg  <= beat_cnt_next;
            if (flush) begin
                vld_pipe_reg <= '0;
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
            end else begin
                vld_pipe_reg <= vld_pipe_next;
                if (fifo_wr) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                if (fifo_rd) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                if (fifo_wr && !fifo_rd)      count_reg <= count_reg + 1'b1;
                else if (!fifo_wr && fifo_rd) count_reg <= count_reg - 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (fifo_wr && !flush) begin
            fifo_mem[wr_ptr_reg] <= ram_dout;
        end
    end

    // The credit rule must keep a returning read from ever hitting a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_wr && (count_reg == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_adc_fft_buf_reader.sv
// Bench for adc_fft_buf_reader: two instances (RD_LAT=1 and RD_LAT=2) share
// all stimulus; each frame's expected beats are computed from the RAM image.
module tb_adc_fft_buf_reader;
    logic        clk = 1'b0;
    logic        rst, start, abort, m_ready;
    logic [11:0] base_addr, frame_len;
    logic [1:0]  busy, done, ceb, oce, mv, ml;
    logic [11:0] adb [2];
    logic [7:0]  dout [2];
    logic [7:0]  md [2];
    logic [7:0]  mem [4096];

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance reference state.
    int          beats [2];
    int          issued [2];
    int          exp_len [2];
    int          done_cnt [2];
    int          abort_age [2];
    logic [11:0] exp_base [2];
    bit          frame_on [2];
    bit          aborted [2];
    bit          stall [2];
    bit          prev_done [2];
    logic [7:0]  stall_data [2];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            adc_fft_buf_reader_if #(.DW(8)) sif ();
            logic [7:0] q1, q2;

            assign sif.ready = m_ready;
            assign mv[gi]    = sif.valid;
            assign ml[gi]    = sif.last;
            assign md[gi]    = sif.data;

            adc_fft_buf_reader #(.AW(12), .DW(8), .RD_LAT(gi + 1), .FIFO_DEPTH(4)) dut (
                .clk       (clk),
                .reset     (rst),
                .start     (start),
                .base_addr (base_addr),
                .frame_len (frame_len),
                .abort     (abort),
                .busy      (busy[gi]),
                .done      (done[gi]),
                .ram_adb   (adb[gi]),
                .ram_ceb   (ceb[gi]),
                .ram_oce   (oce[gi]),
                .ram_dout  (dout[gi]),
                .m         (sif)
            );

            // RAM port B: bypass read, plus optional output register.
            always @(posedge clk) begin
                if (ceb[gi]) q1 <= mem[adb[gi]];
                if (oce[gi]) q2 <= q1;
            end
            assign dout[gi] = (gi == 0) ? q1 : q2;
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Observe both instances for the current cycle and update the reference.
    task automatic monitor();
        logic [11:0] a;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                frame_on[d] = 0; aborted[d] = 0; stall[d] = 0; prev_done[d] = 0;
                continue;
            end
            if (aborted[d]) begin
                abort_age[d]++;
                if (abort_age[d] == 1) begin
                    check_eq("abort_valid_drop", mv[d], 0);
                    check_eq("abort_no_last", ml[d], 0);
                end
                if (abort_age[d] == 2) check_eq("abort_done", done[d], 1);
            end
            if (stall[d]) begin
                check_eq("hold_valid", mv[d], 1);
                check_eq("hold_data", md[d], stall_data[d]);
            end
            if (ceb[d]) begin
                a = exp_base[d] + 12'(issued[d]);
                check_eq("ram_adb", adb[d], a);
                check_eq("issue_in_frame", frame_on[d] && !aborted[d] && issued[d] < exp_len[d], 1);
                check_eq("credit", (issued[d] - beats[d]) < 4, 1);
                issued[d]++;
            end
            if (mv[d]) begin
                a = exp_base[d] + 12'(beats[d]);
                check_eq("beat_data", md[d], mem[a]);
                check_eq("beat_last", ml[d], beats[d] == exp_len[d] - 1);
                if (m_ready) beats[d]++;
            end else if (ml[d]) begin
                check_eq("last_without_valid", ml[d], 0);
            end
            stall[d]      = mv[d] && !m_ready;
            stall_data[d] = md[d];
            if (done[d]) begin
                check_eq("done_pulse", prev_done[d], 0);
                check_eq("busy_at_done", busy[d], 0);
                if (!aborted[d]) begin
                    check_eq("beat_total", beats[d], exp_len[d]);
                    check_eq("issue_total", issued[d], exp_len[d]);
                end
                frame_on[d] = 0;
                done_cnt[d]++;
            end
            prev_done[d] = done[d];
            if (start && !busy[d]) begin
                frame_on[d] = 1; aborted[d] = 0; beats[d] = 0; issued[d] = 0;
                exp_base[d] = base_addr;
                exp_len[d]  = (frame_len == 0) ? 4096 : int'(frame_len);
            end else if (abort && busy[d] && !aborted[d]) begin
                aborted[d] = 1; abort_age[d] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ready(input int mode);
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = 1'b0;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            drive_ready(mode);
            tick();
        end
    endtask

    task automatic start_frame(input logic [11:0] b, input logic [11:0] l);
        base_addr = b; frame_len = l; start = 1'b1;
        tick();
        start = 1'b0; base_addr = 12'($urandom); frame_len = 12'($urandom);
    endtask

    task automatic wait_done(input int budget, input int mode);
        int d0 = done_cnt[0];
        int d1 = done_cnt[1];
        int cycles = 0;
        while ((done_cnt[0] == d0 || done_cnt[1] == d1) && cycles < budget) begin
            drive_ready(mode);
            tick();
            cycles++;
        end
        check_eq("frame_in_budget", cycles < budget, 1);
    endtask

    task automatic check_reset();
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_busy", busy[d], 0);
            check_eq("rst_done", done[d], 0);
            check_eq("rst_ceb", ceb[d], 0);
            check_eq("rst_adb", adb[d], 0);
            check_eq("rst_valid", mv[d], 0);
            check_eq("rst_last", ml[d], 0);
            check_eq("rst_data", md[d], 0);
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int d = 0; d < 2; d++) begin
            beats[d] = 0; issued[d] = 0; exp_len[d] = 0; done_cnt[d] = 0; abort_age[d] = 0;
            exp_base[d] = '0;
        end
        rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        base_addr = '0; frame_len = '0;
        @(posedge clk); #1;
        run_cycles(3, 0);
        rst = 1'b0;
        check_reset();

        // Basic frame at full rate, with a start while busy that must be ignored.
        start_frame(12'd0, 12'd8);
        run_cycles(3, 0);
        base_addr = 12'd100; frame_len = 12'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(8 + 6, 0);

        // Backpressure: toggling ready, then a long stall that fills the credit.
        start_frame(12'($urandom), 12'd16);
        run_cycles(12, 1);
        run_cycles(10, 2);
        for (int d = 0; d < 2; d++) check_eq("credit_fill", issued[d] - beats[d], 4);
        wait_done(60, 0);

        // Address wrap at the top of the buffer.
        start_frame(12'd4094, 12'd4);
        wait_done(4 + 6, 0);

        // Full buffer (length 0) at full rate.
        start_frame(12'd1234, 12'd0);
        wait_done(4096 + 6, 0);

        // Randomized frames with random backpressure.
        for (int f = 0; f < 6; f++) begin
            start_frame(12'($urandom), 12'($urandom_range(1, 40)));
            wait_done(400, 3);
        end

        // Abort after five beats, then a fresh frame from a new base.
        start_frame(12'd500, 12'd32);
        guard = 0;
        while (beats[0] < 5 && guard < 20) begin
            run_cycles(1, 0);
            guard++;
        end
        check_eq("abort_reached_5", beats[0] >= 5, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run_cycles(3, 0);
        start_frame(12'($urandom), 12'd20);
        wait_done(200, 3);

        // Reset in the middle of a streaming frame.
        start_frame(12'd2000, 12'd64);
        guard = 0;
        while (mv != 2'b11 && guard < 10) begin
            run_cycles(1, 0);
            guard++;
        end
        check_eq("valid_before_reset", mv, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset();
        start_frame(12'($urandom), 12'($urandom_range(1, 40)));
        wait_done(400, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adc_fft_buf_reader.md
Name: adc_fft_buf_reader

Overview:
- Read-side controller for the ADC→FFT sample buffer, an 8-bit × 4096 simple dual-port RAM. An upstream writer fills the RAM through port A.
- On a start command, this block drives read port B to fetch one frame of FRAME_LEN samples from a base address, hiding the RAM's fixed read latency.
- It presents the samples as a valid/ready stream with a last marker to the FFT input stage, and absorbs backpressure in a small skid FIFO so no sample is lost or duplicated.

Parameters:
- AW, 12, RAM address width; buffer depth is 2^AW.
- DW, 8, sample width.
- RD_LAT, 1, RAM read latency in cycles from address/ceb to valid dout. Legal values: 1 (bypass read mode) or 2 (output register, oce used).
- FIFO_DEPTH, 4, skid FIFO entries. Must be ≥ RD_LAT+2.

Ports:
- clk  in  1  single clock; also drives RAM port B (clkb).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only when busy=0.
- base_addr  in  AW  first read address, sampled on accepted start.
- frame_len  in  AW  samples per frame, sampled on accepted start; 0 means 2^AW.
- abort  in  1  terminates the current frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat handshakes, or after abort.
- ram_adb  out  AW  port-B read address.
- ram_ceb  out  1  port-B read enable.
- ram_oce  out  1  port-B output-register enable; constant 1.
- ram_dout  in  DW  port-B read data.
- m_data  out  DW  sample to FFT.
- m_valid  out  1  m_data valid.
- m_ready  in  1  FFT accepts a beat when m_valid & m_ready.
- m_last  out  1  high with the final sample of the frame.

Behaviour:
- Reset values: busy=0, done=0, ram_ceb=0, ram_adb=0, m_valid=0, m_last=0, m_data=0. FIFO is emptied, in-flight pipe is cleared, state=IDLE.
- Reset takes priority over every other input in the same cycle.

State machine:
- IDLE: on start, latch base_addr into rd_addr and frame_len into issue_cnt and beat_cnt (0 maps to 2^AW), set busy=1, go to RUN. A start while busy=1 is ignored.
- RUN: issue a read (ram_ceb=1, ram_adb=rd_addr) in any cycle where issue_cnt>0 and inflight+fifo_count < FIFO_DEPTH.
  - Each issued read increments rd_addr modulo 2^AW (4095→0 wraps) and decrements issue_cnt.
  - Go to DRAIN once issue_cnt reaches 0.
- DRAIN: no new reads are issued. Go to FIN when the beat whose beat_cnt reaches 0 handshakes.
- FIN: done=1 for one cycle, busy=0, return to IDLE.

Read pipeline:
- A RD_LAT-deep valid shift register tracks issued reads.
- ram_dout is written into the FIFO in exactly the cycle the matching valid exits the shift register.
- inflight is the count of set bits in that shift register.
- The credit rule above guarantees the FIFO never overflows; a FIFO write into a full FIFO is a design error and asserts in simulation.

Stream output:
- m_valid = FIFO not empty; m_data = FIFO head; data is held stable while m_valid & !m_ready.
- m_last = m_valid & (beat_cnt==1).
- beat_cnt decrements on each handshake.
- Same-cycle FIFO write and read is legal; the count is unchanged.
- Throughput is 1 beat/cycle with m_ready held high. First m_valid appears RD_LAT+1 cycles after the accepted start.

Abort:
- In RUN or DRAIN: stop issuing reads; flush the FIFO and in-flight pipe the next cycle; drop m_valid the next cycle with no m_last; done=1 the following cycle.
- In IDLE: no effect.
- Abort in the same cycle as an accepted start: start wins; abort is ignored.

Width rules:
- issue_cnt and beat_cnt are AW+1 bits so they can hold 2^AW.

Test Plan:
1. RD_LAT=1, base=0, len=8, m_ready=1 → ram_adb 0..7 on consecutive cycles; m_data equals RAM contents at 0..7; m_last only on the 8th beat; done pulses one cycle after; busy low afterwards.
2. Backpressure: len=16, m_ready toggles 1/0 every cycle, then held 0 for 10 cycles → exactly 16 beats in order, no duplicates; ram_ceb stalls once inflight+fifo=4; m_data stable while stalled.
3. Wrap: base=4094, len=4 → ram_adb sequence 4094, 4095, 0, 1; data matches those addresses.
4. Full frame: len=0 → 4096 beats; m_last on beat 4096; ram_adb ends at base-1 mod 4096.
5. Abort after 5 beats of len=32 → m_valid low within 1 cycle, no m_last, done 2 cycles after abort. A fresh start then streams correctly from its new base.
6. Reset mid-frame with m_valid=1, and start while busy → all outputs return to reset values the next cycle; the start while busy is ignored and the running frame is unaffected. Repeat scenarios 1–2 with RD_LAT=2 and confirm identical beat sequences.
